// File: rtl/regfile_renamed.sv
// Integer register file with per-register rename state (busy + ROB producer tag).
// Commit and flush bypass into the read ports; issue takes effect on the next cycle.
module regfile_renamed #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned NREAD = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_rd,
  input  logic [TAG_W-1:0]       iss_tag,
  input  logic                   cmt_en,
  input  logic [AW-1:0]          cmt_rd,
  input  logic [TAG_W-1:0]       cmt_tag,
  input  logic [XLEN-1:0]        cmt_data,
  input  logic [NREAD-1:0]       re,
  input  logic [NREAD*AW-1:0]    raddr,
  output logic [NREAD*XLEN-1:0]  rdata,
  output logic [NREAD-1:0]       rbusy,
  output logic [NREAD*TAG_W-1:0] rtag,
  output logic [AW:0]            busy_cnt
);

  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0]  r_data [NREG];
  logic [TAG_W-1:0] r_tag  [NREG];
  logic [NREG-1:0]  r_busy;

  logic w_iss_wr;
  logic w_cmt_wr;
  logic w_cmt_clr;

  assign w_iss_wr  = iss_en && (iss_rd != '0);
  assign w_cmt_wr  = cmt_en && (cmt_rd != '0);
  // Only the youngest producer may retire the rename; older commits just write data.
  assign w_cmt_clr = w_cmt_wr && r_busy[cmt_rd] && (r_tag[cmt_rd] == cmt_tag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '{default: '0};
      r_tag  <= '{default: '0};
      r_busy <= '0;
    end else begin
      if (w_cmt_wr) r_data[cmt_rd] <= cmt_data;
      if (flush) begin
        r_busy <= '0;
        r_tag  <= '{default: '0};
      end else begin
        if (w_cmt_clr) r_busy[cmt_rd] <= 1'b0;
        if (w_iss_wr) begin
          r_busy[iss_rd] <= 1'b1;
          r_tag[iss_rd]  <= iss_tag;
        end
      end
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_en;
    logic          w_byp;

    assign w_ra  = raddr[p*AW +: AW];
    assign w_en  = !rst && re[p] && (w_ra != '0);
    assign w_byp = w_cmt_wr && (cmt_rd == w_ra);

    assign rdata[p*XLEN +: XLEN]  = !w_en ? '0 : (w_byp ? cmt_data : r_data[w_ra]);
    assign rbusy[p]               = w_en && !flush && r_busy[w_ra] && !(w_byp && w_cmt_clr);
    assign rtag[p*TAG_W +: TAG_W] = (w_en && !flush) ? r_tag[w_ra] : '0;
  end

  assign busy_cnt = CW'($countones(r_busy));

endmodule

// File: tb/tb_regfile_renamed.sv
// Self-checking bench for regfile_renamed: directed scenarios then random traffic
// against an array-based reference model.
module tb_regfile_renamed;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREG  = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned NREAD = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush;
  logic                   iss_en;
  logic [AW-1:0]          iss_rd;
  logic [TAG_W-1:0]       iss_tag;
  logic                   cmt_en;
  logic [AW-1:0]          cmt_rd;
  logic [TAG_W-1:0]       cmt_tag;
  logic [XLEN-1:0]        cmt_data;
  logic [NREAD-1:0]       re;
  logic [NREAD*AW-1:0]    raddr;
  logic [NREAD*XLEN-1:0]  rdata;
  logic [NREAD-1:0]       rbusy;
  logic [NREAD*TAG_W-1:0] rtag;
  logic [AW:0]            busy_cnt;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [XLEN-1:0]  m_data [NREG];
  logic             m_busy [NREG];
  logic [TAG_W-1:0] m_tag  [NREG];

  regfile_renamed #(
    .XLEN(XLEN), .NREG(NREG), .AW(AW), .TAG_W(TAG_W), .NREAD(NREAD)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .iss_en(iss_en), .iss_rd(iss_rd), .iss_tag(iss_tag),
    .cmt_en(cmt_en), .cmt_rd(cmt_rd), .cmt_tag(cmt_tag), .cmt_data(cmt_data),
    .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .rtag(rtag),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_data[i] = '0;
      m_busy[i] = 1'b0;
      m_tag[i]  = '0;
    end
  endtask

  function automatic int model_cnt();
    int n = 0;
    for (int i = 0; i < NREG; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic idle();
    flush = 1'b0; iss_en = 1'b0; iss_rd = '0; iss_tag = '0;
    cmt_en = 1'b0; cmt_rd = '0; cmt_tag = '0; cmt_data = '0;
    re = '0; raddr = '0;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a);
    re[p] = 1'b1;
    raddr[p*AW +: AW] = a;
  endtask

  task automatic issue(input logic [AW-1:0] r, input logic [TAG_W-1:0] t);
    iss_en = 1'b1; iss_rd = r; iss_tag = t;
  endtask

  task automatic commit(input logic [AW-1:0] r, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] d);
    cmt_en = 1'b1; cmt_rd = r; cmt_tag = t; cmt_data = d;
  endtask

  // Expected read result for every port from model state plus the current inputs.
  task automatic check_all(input string tag);
    for (int p = 0; p < NREAD; p++) begin
      logic [AW-1:0]    a;
      logic [XLEN-1:0]  ed;
      logic             eb;
      logic [TAG_W-1:0] et;
      logic             hit;
      a  = raddr[p*AW +: AW];
      ed = '0; eb = 1'b0; et = '0;
      if (!rst && re[p] && a != 0) begin
        hit = cmt_en && (cmt_rd == a);
        ed  = hit ? cmt_data : m_data[a];
        eb  = m_busy[a] && !(hit && m_tag[a] == cmt_tag);
        et  = m_tag[a];
        if (flush) begin eb = 1'b0; et = '0; end
      end
      chk($sformatf("%s p%0d data", tag, p), rdata[p*XLEN +: XLEN], ed);
      chk($sformatf("%s p%0d busy", tag, p), 32'(rbusy[p]), 32'(eb));
      chk($sformatf("%s p%0d tag", tag, p), 32'(rtag[p*TAG_W +: TAG_W]), 32'(et));
    end
    chk({tag, " busy_cnt"}, 32'(busy_cnt), 32'(model_cnt()));
  endtask

  // Advance one clock: apply the architectural rules to the model, then return at the next negedge.
  task automatic tick();
    if (!rst) begin
      if (cmt_en && cmt_rd != 0) begin
        m_data[cmt_rd] = cmt_data;
        if (m_busy[cmt_rd] && m_tag[cmt_rd] == cmt_tag) m_busy[cmt_rd] = 1'b0;
      end
      if (flush) begin
        for (int i = 0; i < NREG; i++) begin m_busy[i] = 1'b0; m_tag[i] = '0; end
      end else if (iss_en && iss_rd != 0) begin
        m_busy[iss_rd] = 1'b1;
        m_tag[iss_rd]  = iss_tag;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rd(0, 5'd5);
    #1 check_all("reset");
    chk("reset busy_cnt const", 32'(busy_cnt), 0);
    tick();
    rst = 1'b0;
    tick();

    // rename then commit
    issue(5'd5, 4'd2); tick(); idle();
    rd(0, 5'd5);
    #1 check_all("ren x5");
    chk("ren x5 busy const", 32'(rbusy[0]), 1);
    chk("ren x5 tag const", 32'(rtag[3:0]), 2);
    chk("ren cnt const", 32'(busy_cnt), 1);
    commit(5'd5, 4'd2, 32'h1234_5678);
    #1 check_all("cmt x5 byp");
    chk("cmt x5 byp data const", rdata[31:0], 32'h1234_5678);
    chk("cmt x5 byp busy const", 32'(rbusy[0]), 0);
    tick(); idle();
    rd(0, 5'd5);
    #1 check_all("cmt x5 state");
    chk("cmt x5 cnt const", 32'(busy_cnt), 0);

    // stale commit from an older producer
    issue(5'd7, 4'd1); tick();
    issue(5'd7, 4'd4); tick(); idle();
    commit(5'd7, 4'd1, 32'h0000_00AA); tick(); idle();
    rd(0, 5'd7);
    #1 check_all("stale x7");
    chk("stale x7 data const", rdata[31:0], 32'h0000_00AA);
    chk("stale x7 busy const", 32'(rbusy[0]), 1);
    chk("stale x7 tag const", 32'(rtag[3:0]), 4);
    commit(5'd7, 4'd4, 32'h0000_00BB); tick(); idle();
    rd(1, 5'd7);
    #1 check_all("young x7");
    chk("young x7 busy const", 32'(rbusy[1]), 0);

    // same-cycle issue and commit: issue wins rename state
    issue(5'd9, 4'd5); tick(); idle();
    issue(5'd9, 4'd6); commit(5'd9, 4'd5, 32'h55);
    tick(); idle();
    rd(0, 5'd9);
    #1 check_all("iss+cmt x9");
    chk("iss+cmt x9 data const", rdata[31:0], 32'h55);
    chk("iss+cmt x9 tag const", 32'(rtag[3:0]), 6);

    // flush drops a same-cycle issue
    flush = 1'b1; issue(5'd3, 4'd2); rd(0, 5'd9);
    #1 check_all("flush+iss byp");
    tick(); idle();
    rd(0, 5'd3);
    #1 check_all("flush+iss after");
    chk("flush+iss cnt const", 32'(busy_cnt), 0);

    // multi-port bypass on x10
    issue(5'd10, 4'd1); tick(); idle();
    commit(5'd10, 4'd1, 32'h0F0F_0F0F);
    rd(0, 5'd10); rd(1, 5'd10); rd(2, 5'd10);
    #1 check_all("mport all");
    chk("mport p2 data const", rdata[95:64], 32'h0F0F_0F0F);
    re[2] = 1'b0;
    #1 check_all("mport re0");
    chk("mport re0 data const", rdata[95:64], 0);
    tick(); idle();

    // bulk rename then flush
    for (int r = 1; r < NREG; r++) begin
      issue(AW'(r), TAG_W'(r)); tick();
    end
    idle();
    rd(0, 5'd31);
    #1 chk("bulk cnt const", 32'(busy_cnt), 31);
    flush = 1'b1; rd(1, 5'd1); rd(2, 5'd16);
    #1 check_all("bulk flush byp");
    tick(); idle();
    rd(0, 5'd5); rd(1, 5'd10); rd(2, 5'd31);
    #1 check_all("bulk flush after");
    chk("bulk data x5 const", rdata[31:0], 32'h1234_5678);
    chk("bulk cnt zero const", 32'(busy_cnt), 0);

    // asynchronous reset mid-run, with traffic held on the inputs
    issue(5'd12, 4'd3); tick();
    commit(5'd12, 4'd7, 32'hCAFE_0001); rd(0, 5'd12); rd(1, 5'd5);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all("mid rst");
    chk("mid rst cnt const", 32'(busy_cnt), 0);
    chk("mid rst data const", rdata[31:0], 0);
    tick();
    rst = 1'b0; idle();
    issue(5'd0, 4'd3); commit(5'd0, 4'd3, 32'hDEAD_BEEF);
    tick(); idle();
    rd(0, 5'd0); rd(1, 5'd12); rd(2, 5'd5);
    #1 check_all("x0 after rst");
    chk("x0 data const", rdata[31:0], 0);
    chk("x0 cnt const", 32'(busy_cnt), 0);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      idle();
      iss_en   = 1'($urandom_range(0, 1));
      iss_rd   = AW'($urandom);
      iss_tag  = TAG_W'($urandom);
      cmt_en   = 1'($urandom_range(0, 1));
      cmt_rd   = ($urandom_range(0, 3) == 0) ? iss_rd : AW'($urandom);
      cmt_tag  = ($urandom_range(0, 1) == 1) ? m_tag[cmt_rd] : TAG_W'($urandom);
      cmt_data = $urandom;
      flush    = ($urandom_range(0, 19) == 0);
      re       = NREAD'($urandom);
      for (int p = 0; p < NREAD; p++)
        raddr[p*AW +: AW] = ($urandom_range(0, 2) == 0) ? cmt_rd : AW'($urandom);
      #1 check_all($sformatf("rand%0d", c));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_renamed.md
Name: regfile_renamed

Overview:
- Parametrised integer register file with per-register rename state (busy bit plus producer tag) for the out-of-order core.
- Sits between dispatch, the reorder buffer (ROB) and the reservation stations.
- Dispatch marks destination registers busy with a ROB tag; in-order commit writes architectural data and clears busy only when the tag matches.
- Provides NREAD read ports, each returning data, busy and tag. Commit data and flush are bypassed into the read results in the same cycle.

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of architectural registers (power of two; register 0 hard-wired zero)
AW, 5, register address width, equal to log2(NREG)
TAG_W, 4, ROB tag width
NREAD, 2, number of read ports

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  clears all busy bits (mispredict/exception)
iss_en  in  1  dispatch rename request
iss_rd  in  AW  destination register being renamed
iss_tag  in  TAG_W  ROB tag assigned to iss_rd
cmt_en  in  1  ROB commit strobe
cmt_rd  in  AW  committed destination register
cmt_tag  in  TAG_W  ROB tag of committing entry
cmt_data  in  XLEN  committed result
re  in  NREAD  per-port read enable
raddr  in  NREAD*AW  read addresses, port i at [i*AW +: AW]
rdata  out  NREAD*XLEN  read data, port i at [i*XLEN +: XLEN]
rbusy  out  NREAD  register awaiting an uncommitted producer
rtag  out  NREAD*TAG_W  producer tag, valid only when rbusy[i]=1
busy_cnt  out  AW+1  number of busy registers

Behaviour:
- Reset (asynchronous, rst=1):
  - All data words, busy bits and tags are cleared to 0 immediately.
  - While rst=1: all rdata/rbusy/rtag read 0 and busy_cnt=0.
  - No writes take place while rst=1.
- Register 0:
  - Never written and never busy.
  - Issue or commit to rd=0 is ignored.
  - Reads of address 0 return data 0, busy 0, tag 0.
- Issue (iss_en=1, iss_rd!=0): at the next edge, busy[iss_rd]=1 and tag[iss_rd]=iss_tag.
  - Re-issuing to an already-busy register overwrites the tag.
- Commit (cmt_en=1, cmt_rd!=0):
  - At the next edge, data[cmt_rd]=cmt_data unconditionally.
  - busy[cmt_rd] is cleared only if busy[cmt_rd]=1 and tag[cmt_rd]==cmt_tag. On a tag mismatch the register stays busy with its tag unchanged (a younger producer exists).
- Issue and commit to the same rd in one cycle: data is written, and busy=1 with tag=iss_tag (issue wins).
- Flush=1: at the next edge, all busy bits are cleared and tags are zeroed.
  - A same-cycle issue is dropped.
  - A same-cycle commit still writes data.
- Read ports: purely combinational, zero latency. Per port i, in priority order:
  - re[i]=0: outputs 0.
  - raddr==0: outputs 0.
  - Commit bypass, when cmt_en=1 and cmt_rd==raddr: rdata=cmt_data. Additionally, rbusy=0 if that commit clears busy (matching tag), else busy/tag come from state.
  - Otherwise: rdata, rbusy and rtag come from state.
  - flush=1 forces rbusy=0 and rtag=0 on every port.
  - A same-cycle issue is not reflected until the next cycle (no issue bypass).
- All read ports are independent; several ports may read the same address with identical results.
- busy_cnt: popcount of the registered busy vector, range 0..NREG-1. It reflects state only (no same-cycle bypass).
- No handshake back-pressure: every request is accepted every cycle.

Test Plan:
- Reset/x0: assert rst mid-run after writes. Expect rdata=0, rbusy=0 and busy_cnt=0 immediately. After release, issue rd=0 tag=3 and commit rd=0 data=0xDEADBEEF; a read of x0 returns 0/0/0.
- Rename then commit:
  - Issue rd=5 tag=2; next cycle a read of x5 gives rbusy=1, rtag=2, busy_cnt=1.
  - Commit rd=5 tag=2 data=0x12345678; in that same cycle the read gives rdata=0x12345678, rbusy=0.
  - Next cycle the state holds the same values and busy_cnt=0.
- Stale commit: issue rd=7 tag=1, then issue rd=7 tag=4, then commit rd=7 tag=1 data=0xAA. Expect data[7]=0xAA, rbusy=1, rtag=4. A later commit with tag=4 clears it.
- Simultaneous events:
  - Same cycle: issue rd=9 tag=6 with commit rd=9 tag=(matching old tag) data=0x55. Expect data=0x55, busy=1, tag=6 next cycle.
  - Flush together with issue rd=3 tag=2. Expect busy_cnt=0 and x3 not busy.
- Multi-port: NREAD=3, all ports read x10 while a commit to x10 data=0x0F0F0F0F is in progress. All three ports return the bypassed data. Port with re=0 returns zeros.
- Flush bulk: busy registers 1..31 (busy_cnt=31), then pulse flush. Same-cycle reads show rbusy=0; the next cycle busy_cnt=0 and data is preserved.
